// File: rtl/ray_direction_gen.sv
// Raster-scan camera-ray generator: one Q4.8 (x,y,z) direction per pixel.
// Ports: clock/reset, start/hold in; x/y/z_out, out_id, px/py_out, busy, frame_done out.
module ray_direction_gen #(
  parameter int H_RES    = 64,
  parameter int V_RES    = 64,
  parameter int STEP     = 8,
  parameter int FOCAL    = 256,
  parameter int ID_WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      hold,
  output logic [11:0]               x_out,
  output logic [11:0]               y_out,
  output logic [11:0]               z_out,
  output logic [ID_WIDTH-1:0]       out_id,
  output logic [$clog2(H_RES)-1:0]  px_out,
  output logic [$clog2(V_RES)-1:0]  py_out,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int PXW = $clog2(H_RES);
  localparam int PYW = $clog2(V_RES);

  localparam logic signed [11:0] X0 = 12'(-(H_RES / 2) * STEP);
  localparam logic signed [11:0] Y0 = 12'((V_RES / 2) * STEP);
  localparam logic signed [11:0] DS = 12'(STEP);
  localparam logic signed [11:0] ZF = 12'(FOCAL);

  localparam logic [PXW-1:0] PX_LAST = PXW'(H_RES - 1);
  localparam logic [PYW-1:0] PY_LAST = PYW'(V_RES - 1);
  localparam logic [PXW-1:0] PX_ONE  = PXW'(1);
  localparam logic [PYW-1:0] PY_ONE  = PYW'(1);
  localparam logic [ID_WIDTH-1:0] ID_ONE = ID_WIDTH'(1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t state, state_n;

  logic [PXW-1:0]      px_cnt, px_n, cur_px;
  logic [PYW-1:0]      py_cnt, py_n, cur_py;
  logic signed [11:0]  x_acc, x_n, cur_x;
  logic signed [11:0]  y_acc, y_n, cur_y;
  logic [ID_WIDTH-1:0] id_cnt, id_n, cur_id;
  logic                run, emit, line_end, last;

  // In IDLE the pointer is taken from constants so a start edge
  // always presents pixel (0,0) with ID 1.
  always_comb begin
    run      = (state == S_RUN);
    cur_px   = run ? px_cnt : '0;
    cur_py   = run ? py_cnt : '0;
    cur_x    = run ? x_acc  : X0;
    cur_y    = run ? y_acc  : Y0;
    cur_id   = run ? id_cnt : ID_ONE;
    emit     = (run | start) & ~hold;
    line_end = (cur_px == PX_LAST);
    last     = line_end & (cur_py == PY_LAST);

    px_n = cur_px;
    py_n = cur_py;
    x_n  = cur_x;
    y_n  = cur_y;
    id_n = cur_id;

    if (emit) begin
      if (line_end) begin
        px_n = '0;
        x_n  = X0;
        py_n = cur_py + PY_ONE;
        y_n  = cur_y - DS;
      end else begin
        px_n = cur_px + PX_ONE;
        x_n  = cur_x + DS;
      end
      // ID 0 is reserved for bubbles
      id_n = (cur_id == '1) ? ID_ONE : cur_id + ID_ONE;
    end

    state_n = state;
    unique case (state)
      S_IDLE: if (start) state_n = S_RUN;
      S_RUN:  if (emit && last) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      px_cnt     <= '0;
      py_cnt     <= '0;
      x_acc      <= X0;
      y_acc      <= Y0;
      id_cnt     <= ID_ONE;
      x_out      <= '0;
      y_out      <= '0;
      z_out      <= '0;
      out_id     <= '0;
      px_out     <= '0;
      py_out     <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      px_cnt     <= px_n;
      py_cnt     <= py_n;
      x_acc      <= x_n;
      y_acc      <= y_n;
      id_cnt     <= id_n;
      x_out      <= emit ? cur_x  : '0;
      y_out      <= emit ? cur_y  : '0;
      z_out      <= emit ? ZF     : '0;
      out_id     <= emit ? cur_id : '0;
      px_out     <= emit ? cur_px : '0;
      py_out     <= emit ? cur_py : '0;
      busy       <= (state_n == S_RUN);
      frame_done <= emit & last;
    end
  end

endmodule
